// File: rtl/i2c_pin_pacer_if.sv
// Bus between display_ls and the I2C pin pacer: the ap_vld line updates, the
// SCL pad readback, the open-drain enables and the status/debug outputs.
interface i2c_pin_pacer_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    SDA;
    logic          SDA_ap_vld;
    logic [7:0]    SCL;
    logic          SCL_ap_vld;
    logic          scl_pad_in;
    logic          sda_oe;
    logic          scl_oe;
    logic          busy;
    logic [LW-1:0] level;
    logic          overflow;
    logic          stretch_err;
    logic [1:0]    fsm_state;   // debug view of the pacer FSM (0 IDLE, 1 STRETCH, 2 HOLD)

    // Update strobes are single-cycle and unconditionally accepted; there is
    // no ready. A strobe arriving while the FIFO is full and not popping is
    // dropped and recorded in the sticky overflow flag.
    modport master (
        output SDA, SDA_ap_vld, SCL, SCL_ap_vld, scl_pad_in,
        input  sda_oe, scl_oe, busy, level, overflow, stretch_err, fsm_state
    );

    modport slave (
        input  SDA, SDA_ap_vld, SCL, SCL_ap_vld, scl_pad_in,
        output sda_oe, scl_oe, busy, level, overflow, stretch_err, fsm_state
    );
endinterface

// File: rtl/i2c_pin_pacer.sv
// I2C pin pacer: captures SDA/SCL ap_vld updates from display_ls into a FIFO
// and replays them onto open-drain pad enables, one line state per
// HOLD_CYCLES, waiting (bounded) for the slave to release SCL.
module i2c_pin_pacer #(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 125,
    parameter int STRETCH_MAX = 50000
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    i2c_pin_pacer_if.slave   bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int CMAX = (HOLD_CYCLES > STRETCH_MAX) ? HOLD_CYCLES : STRETCH_MAX;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          sda_req, scl_req;
    logic          ev, ev_sda, ev_scl;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          full, push_ok, drop, pop, load;
    logic [1:0]    head;
    logic          scl_s1, scl_s2;
    logic          sda_oe_r, scl_oe_r, sda_oe_nx, scl_oe_nx;
    logic          overflow_r, stretch_err_r, err_set;

    // Build the event: a strobed line takes its new value, the other keeps its shadow.
    always_comb begin
        ev     = bus.SDA_ap_vld | bus.SCL_ap_vld;
        ev_sda = bus.SDA_ap_vld ? (bus.SDA != 8'd0) : sda_req;
        ev_scl = bus.SCL_ap_vld ? (bus.SCL != 8'd0) : scl_req;
    end

    assign full    = (level == LW'(DEPTH));
    assign push_ok = ev && (!full || pop);
    assign drop    = ev && full && !pop;
    assign head    = mem[rd_ptr];

    // Shadow registers remember the last requested level of each line.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            sda_req <= 1'b1;
            scl_req <= 1'b1;
        end else if (ev) begin
            sda_req <= ev_sda;
            scl_req <= ev_scl;
        end
    end

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge ap_clk) begin
        if (push_ok) mem[wr_ptr] <= {ev_scl, ev_sda};
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) overflow_r <= 1'b1;
        end
    end

    // Two-flop synchroniser for the SCL pad, preset to the released level.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_pad_in;
            scl_s2 <= scl_s1;
        end
    end

    // FSM state, counter, pad enables and the sticky stretch error.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            sda_oe_r      <= 1'b0;
            scl_oe_r      <= 1'b0;
            stretch_err_r <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            sda_oe_r <= sda_oe_nx;
            scl_oe_r <= scl_oe_nx;
            if (err_set) stretch_err_r <= 1'b1;
        end
    end

    // Next state: pop only from a registered entry; releasing SCL always passes
    // through STRETCH so the slave can hold the clock low.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        sda_oe_nx = sda_oe_r;
        scl_oe_nx = scl_oe_r;
        pop       = 1'b0;
        load      = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) load = 1'b1;
            end
            STRETCH: begin
                if (scl_s2) begin
                    state_nx = HOLD;
                    cnt_nx   = CW'(HOLD_CYCLES - 1);
                end else if (cnt == CW'(STRETCH_MAX - 1)) begin
                    err_set  = 1'b1;
                    state_nx = HOLD;
                    cnt_nx   = CW'(HOLD_CYCLES - 1);
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt != '0)        cnt_nx   = cnt - 1'b1;
                else if (level != '0) load     = 1'b1;
                else                  state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (load) begin
            pop       = 1'b1;
            sda_oe_nx = ~head[0];
            scl_oe_nx = ~head[1];
            if (head[1]) begin
                state_nx = STRETCH;
                cnt_nx   = '0;
            end else begin
                state_nx = HOLD;
                cnt_nx   = CW'(HOLD_CYCLES - 1);
            end
        end
    end

    assign bus.sda_oe      = sda_oe_r;
    assign bus.scl_oe      = scl_oe_r;
    assign bus.busy        = (level != '0) || (state != IDLE);
    assign bus.level       = level;
    assign bus.overflow    = overflow_r;
    assign bus.stretch_err = stretch_err_r;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_i2c_pin_pacer.sv
// Directed bench for i2c_pin_pacer with small parameters (DEPTH 4, HOLD 10,
// STRETCH_MAX 400). The SCL pad is modelled as open drain: low while the pacer
// pulls it or while the simulated slave stretches the clock.
module tb_i2c_pin_pacer;
    localparam int DEPTH = 4;
    localparam int H     = 10;
    localparam int S     = 400;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_STRETCH = 2'd1, ST_HOLD = 2'd2;

    logic clk = 1'b0;
    logic ap_rst = 1'b0;
    logic slave_hold = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    i2c_pin_pacer_if #(.DEPTH(DEPTH)) bus ();

    i2c_pin_pacer #(.DEPTH(DEPTH), .HOLD_CYCLES(H), .STRETCH_MAX(S)) dut (
        .ap_clk (clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    assign bus.scl_pad_in = ~bus.scl_oe & ~slave_hold;

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        tick();
        tick();
        ap_rst = 1'b0;
        tick();
    endtask

    // Drive one single-cycle update; returns one ns after its capture edge.
    task automatic strobe(input logic sda_v, input logic [7:0] sda, input logic scl_v, input logic [7:0] scl);
        bus.SDA = sda; bus.SDA_ap_vld = sda_v;
        bus.SCL = scl; bus.SCL_ap_vld = scl_v;
        tick();
        bus.SDA_ap_vld = 1'b0;
        bus.SCL_ap_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin tick(); n++; end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s_idle_timeout: busy=%b want 0", name, bus.busy); end
    endtask

    task automatic test_reset();
        bus.SDA = 8'h00; bus.SCL = 8'h00; bus.SDA_ap_vld = 1'b0; bus.SCL_ap_vld = 1'b0;
        do_reset();
        n_cmp++; if (bus.sda_oe !== 1'b0) begin n_bad++; $display("FAIL rst_sda_oe: got %b want 0", bus.sda_oe); end
        n_cmp++; if (bus.scl_oe !== 1'b0) begin n_bad++; $display("FAIL rst_scl_oe: got %b want 0", bus.scl_oe); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.level !== 3'd0) begin n_bad++; $display("FAIL rst_level: got %0d want 0", bus.level); end
        n_cmp++; if (bus.overflow !== 1'b0 || bus.stretch_err !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got %b%b want 00", bus.overflow, bus.stretch_err); end
        n_cmp++; if (bus.fsm_state !== ST_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want 0", bus.fsm_state); end
    endtask

    // SDA low alone: event {scl=1,sda=0}; one STRETCH cycle (pad already high) then HOLD.
    task automatic test_single_update();
        int a;
        strobe(1'b1, 8'h00, 1'b0, 8'h00);
        n_cmp++; if (bus.level !== 3'd1 || bus.sda_oe !== 1'b0) begin n_bad++; $display("FAIL single_capture: level=%0d sda_oe=%b want 1,0", bus.level, bus.sda_oe); end
        tick();
        a = cyc;
        n_cmp++; if (bus.sda_oe !== 1'b1 || bus.scl_oe !== 1'b0) begin n_bad++; $display("FAIL single_apply: sda_oe=%b scl_oe=%b want 1,0", bus.sda_oe, bus.scl_oe); end
        n_cmp++; if (bus.level !== 3'd0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_pop: level=%0d busy=%b want 0,1", bus.level, bus.busy); end
        wait_to(a + H);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_hold: got %b want 1", bus.busy); end
        wait_to(a + H + 1);
        n_cmp++; if (bus.busy !== 1'b0 || bus.sda_oe !== 1'b1) begin n_bad++; $display("FAIL single_busy_fall: busy=%b sda_oe=%b want 0,1", bus.busy, bus.sda_oe); end
    endtask

    // START: {1,0} then {0,0} back to back.
    task automatic test_back_to_back();
        int a;
        do_reset();
        strobe(1'b1, 8'h00, 1'b0, 8'h00);
        strobe(1'b0, 8'h00, 1'b1, 8'h00);
        a = cyc;
        n_cmp++; if (bus.sda_oe !== 1'b1 || bus.scl_oe !== 1'b0 || bus.level !== 3'd1) begin n_bad++; $display("FAIL start_first: sda_oe=%b scl_oe=%b level=%0d want 1,0,1", bus.sda_oe, bus.scl_oe, bus.level); end
        wait_to(a + H);
        n_cmp++; if (bus.scl_oe !== 1'b0) begin n_bad++; $display("FAIL start_scl_early: got %b want 0", bus.scl_oe); end
        wait_to(a + H + 1);
        n_cmp++; if (bus.scl_oe !== 1'b1 || bus.sda_oe !== 1'b1) begin n_bad++; $display("FAIL start_scl_low: scl_oe=%b sda_oe=%b want 1,1", bus.scl_oe, bus.sda_oe); end
        wait_to(a + 2 * H);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL start_busy_hold: got %b want 1", bus.busy); end
        wait_to(a + 2 * H + 1);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL start_busy_fall: got %b want 0", bus.busy); end
    endtask

    // Slave holds SCL low 300 cycles, then a second run exceeding STRETCH_MAX.
    task automatic test_stretch();
        int a;
        slave_hold = 1'b1;
        strobe(1'b0, 8'h00, 1'b1, 8'h01);
        tick();
        a = cyc;
        n_cmp++; if (bus.scl_oe !== 1'b0 || bus.fsm_state !== ST_STRETCH) begin n_bad++; $display("FAIL stretch_enter: scl_oe=%b state=%0d want 0,1", bus.scl_oe, bus.fsm_state); end
        strobe(1'b1, 8'h01, 1'b0, 8'h00);
        wait_to(a + 300);
        slave_hold = 1'b0;
        wait_to(a + 302);
        n_cmp++; if (bus.fsm_state !== ST_STRETCH) begin n_bad++; $display("FAIL stretch_sync_wait: state=%0d want 1", bus.fsm_state); end
        wait_to(a + 303);
        n_cmp++; if (bus.fsm_state !== ST_HOLD || bus.stretch_err !== 1'b0) begin n_bad++; $display("FAIL stretch_release: state=%0d err=%b want 2,0", bus.fsm_state, bus.stretch_err); end
        wait_to(a + 302 + H);
        n_cmp++; if (bus.sda_oe !== 1'b1) begin n_bad++; $display("FAIL stretch_next_early: sda_oe=%b want 1", bus.sda_oe); end
        wait_to(a + 303 + H);
        n_cmp++; if (bus.sda_oe !== 1'b0) begin n_bad++; $display("FAIL stretch_next: sda_oe=%b want 0", bus.sda_oe); end
        wait_idle("stretch_ok");
        slave_hold = 1'b1;
        tick(); tick(); tick();
        strobe(1'b1, 8'h00, 1'b0, 8'h00);
        tick();
        a = cyc;
        wait_to(a + S - 1);
        n_cmp++; if (bus.stretch_err !== 1'b0 || bus.fsm_state !== ST_STRETCH) begin n_bad++; $display("FAIL stretch_err_early: err=%b state=%0d want 0,1", bus.stretch_err, bus.fsm_state); end
        wait_to(a + S);
        n_cmp++; if (bus.stretch_err !== 1'b1 || bus.fsm_state !== ST_HOLD) begin n_bad++; $display("FAIL stretch_err_set: err=%b state=%0d want 1,2", bus.stretch_err, bus.fsm_state); end
        slave_hold = 1'b0;
        wait_idle("stretch_err");
        n_cmp++; if (bus.stretch_err !== 1'b1) begin n_bad++; $display("FAIL stretch_err_sticky: got %b want 1", bus.stretch_err); end
    endtask

    // DEPTH+3 events on consecutive cycles: DEPTH+1 replayed in order, rest dropped.
    task automatic test_overflow();
        logic sdav [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int a;
        do_reset();
        n_cmp++; if (bus.stretch_err !== 1'b0) begin n_bad++; $display("FAIL ovf_err_cleared: got %b want 0", bus.stretch_err); end
        a = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            strobe(1'b1, sdav[i] ? 8'h5a : 8'h00, 1'b1, 8'h00);
            if (i == 0) a = cyc + 1;
            if (i == 1) begin
                n_cmp++; if (bus.sda_oe !== 1'b1 || bus.scl_oe !== 1'b1) begin n_bad++; $display("FAIL ovf_ev0: sda_oe=%b scl_oe=%b want 1,1", bus.sda_oe, bus.scl_oe); end
            end
        end
        n_cmp++; if (bus.level !== 3'd4) begin n_bad++; $display("FAIL ovf_level: got %0d want 4", bus.level); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
        for (int k = 1; k <= DEPTH; k++) begin
            wait_to(a + k * H - 1);
            n_cmp++; if (bus.sda_oe !== ~sdav[k-1]) begin n_bad++; $display("FAIL ovf_pre_ev%0d: sda_oe=%b want %b", k, bus.sda_oe, ~sdav[k-1]); end
            wait_to(a + k * H);
            n_cmp++; if (bus.sda_oe !== ~sdav[k] || bus.scl_oe !== 1'b1) begin n_bad++; $display("FAIL ovf_ev%0d: sda_oe=%b scl_oe=%b want %b,1", k, bus.sda_oe, bus.scl_oe, ~sdav[k]); end
        end
        wait_idle("ovf");
        n_cmp++; if (bus.sda_oe !== 1'b1 || bus.level !== 3'd0) begin n_bad++; $display("FAIL ovf_final: sda_oe=%b level=%0d want 1,0", bus.sda_oe, bus.level); end
    endtask

    // Asynchronous reset while HOLD has three entries queued.
    task automatic test_reset_mid_burst();
        int act = 0;
        do_reset();
        for (int i = 0; i < 4; i++) strobe(1'b1, 8'h00, 1'b1, 8'h00);
        n_cmp++; if (bus.level !== 3'd3 || bus.fsm_state !== ST_HOLD || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL mid_pre: level=%0d state=%0d ovf=%b want 3,2,0", bus.level, bus.fsm_state, bus.overflow); end
        #2 ap_rst = 1'b1;
        #1;
        n_cmp++; if (bus.sda_oe !== 1'b0 || bus.scl_oe !== 1'b0) begin n_bad++; $display("FAIL mid_oe: sda_oe=%b scl_oe=%b want 0,0", bus.sda_oe, bus.scl_oe); end
        n_cmp++; if (bus.level !== 3'd0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_level: level=%0d busy=%b want 0,0", bus.level, bus.busy); end
        tick();
        ap_rst = 1'b0;
        for (int i = 0; i < 3 * H; i++) begin
            tick();
            if (bus.sda_oe !== 1'b0 || bus.scl_oe !== 1'b0 || bus.busy !== 1'b0) act++;
        end
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL mid_quiet: active cycles=%0d want 0", act); end
    endtask

    initial begin
        test_reset();
        test_single_update();
        test_back_to_back();
        test_stretch();
        test_overflow();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
